// File: rtl/jump_pkg.sv
// -----------------------------------------------------------------------------
// jump_pkg
// Shared types for the jump charge controller: FSM state encoding, jump
// direction encoding, default velocity width and a direction decode helper.
// -----------------------------------------------------------------------------
package jump_pkg;

    localparam int VEL_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHARGE   = 2'd1,
        LAUNCH   = 2'd2,
        AIRBORNE = 2'd3
    } jump_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10
    } jump_dir_t;

    // Exactly one of left/right selects a side; none or both means straight up.
    function automatic jump_dir_t dir_decode(input logic left, input logic right);
        jump_dir_t d;
        case ({left, right})
            2'b10:   d = DIR_LEFT;
            2'b01:   d = DIR_RIGHT;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/jump_charge_ctl.sv
// -----------------------------------------------------------------------------
// jump_charge_ctl
// Measures how long space is held while grounded (in frame ticks), converts it
// into a saturating jump velocity, latches the jump direction and issues a
// one-cycle launch request to the movement/physics controller.
//
// Ports:
//   clk          pixel/system clock
//   rst          asynchronous active-high reset
//   frame_tick   one-cycle pulse per frame
//   key_space    space held
//   key_left     left held
//   key_right    right held
//   grounded     character standing on floor/platform
//   jump_req     one-cycle launch pulse
//   jump_vel     launch velocity, valid with jump_req, held until next launch
//   jump_dir     00 up, 01 left, 10 right; valid with jump_req, held after
//   charging     high while charging (sprite select)
//   charge_level live charge value for the power bar
//
// Build option: define JUMP_AUTO_LAUNCH_EN to launch automatically one cycle
// after the charge saturates at VEL_MAX, without waiting for release.
// -----------------------------------------------------------------------------
module jump_charge_ctl
    import jump_pkg::*;
#(
    parameter int VEL_W           = VEL_W_DEFAULT,
    parameter int VEL_MIN         = 4,
    parameter int VEL_MAX         = 24,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             key_space,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             grounded,
    output logic             jump_req,
    output logic [VEL_W-1:0] jump_vel,
    output logic [1:0]       jump_dir,
    output logic             charging,
    output logic [VEL_W-1:0] charge_level
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [VEL_W-1:0] LVL_ZERO = VEL_W'(0);
    localparam logic [VEL_W-1:0] LVL_ONE  = VEL_W'(1);
    localparam logic [VEL_W-1:0] LVL_MIN  = VEL_W'(VEL_MIN);
    localparam logic [VEL_W-1:0] LVL_MAX  = VEL_W'(VEL_MAX);

    jump_state_t      state_r;
    logic [CNT_W-1:0] frame_cnt_r;
    jump_dir_t        dir_r;
    jump_dir_t        jump_dir_r;
    logic             jump_req_r;
    logic [VEL_W-1:0] jump_vel_r;
    logic             charging_r;
    logic [VEL_W-1:0] charge_level_r;

    logic             step_due_s;
    logic [CNT_W-1:0] frame_cnt_next_s;
    logic [VEL_W-1:0] charge_next_s;

    // Charge step arithmetic: frame counter wrap and saturating level increment.
    // A tick arriving in the release cycle is folded in here, so the launch
    // captures the already-incremented value.
    always_comb begin
        step_due_s       = frame_tick && (frame_cnt_r == CNT_LAST);
        frame_cnt_next_s = frame_cnt_r;
        charge_next_s    = charge_level_r;
        if (frame_tick) begin
            if (step_due_s) begin
                frame_cnt_next_s = CNT_ZERO;
            end else begin
                frame_cnt_next_s = frame_cnt_r + CNT_ONE;
            end
        end else begin
            frame_cnt_next_s = frame_cnt_r;
        end
        if (step_due_s) begin
            if (charge_level_r >= LVL_MAX) begin
                charge_next_s = LVL_MAX;
            end else begin
                charge_next_s = charge_level_r + LVL_ONE;
            end
        end else begin
            charge_next_s = charge_level_r;
        end
    end

    // Jump sequencing FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= AIRBORNE;
            frame_cnt_r    <= CNT_ZERO;
            dir_r          <= DIR_UP;
            jump_dir_r     <= DIR_UP;
            jump_req_r     <= 1'b0;
            jump_vel_r     <= LVL_ZERO;
            charging_r     <= 1'b0;
            charge_level_r <= LVL_ZERO;
        end else begin
            jump_req_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!grounded) begin
                        state_r <= AIRBORNE;
                    end else if (key_space) begin
                        state_r        <= CHARGE;
                        charging_r     <= 1'b1;
                        charge_level_r <= LVL_MIN;
                        frame_cnt_r    <= CNT_ZERO;
                        dir_r          <= dir_decode(key_left, key_right);
                    end
                end
                CHARGE: begin
                    if (!grounded) begin
                        // Walked off an edge while charging: abort silently.
                        state_r        <= AIRBORNE;
                        charging_r     <= 1'b0;
                        charge_level_r <= LVL_ZERO;
                        frame_cnt_r    <= CNT_ZERO;
                    end else begin
                        charge_level_r <= charge_next_s;
                        frame_cnt_r    <= frame_cnt_next_s;
                        dir_r          <= dir_decode(key_left, key_right);
                        if (!key_space) begin
                            state_r    <= LAUNCH;
                            charging_r <= 1'b0;
                        end
`ifdef JUMP_AUTO_LAUNCH_EN
                        else if (charge_level_r == LVL_MAX) begin
                            state_r    <= LAUNCH;
                            charging_r <= 1'b0;
                        end
`endif
                    end
                end
                LAUNCH: begin
                    jump_req_r     <= 1'b1;
                    jump_vel_r     <= charge_level_r;
                    jump_dir_r     <= dir_r;
                    charge_level_r <= LVL_ZERO;
                    state_r        <= AIRBORNE;
                end
                AIRBORNE: begin
                    // Landing with space still held must not re-trigger a charge.
                    if (grounded && !key_space) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r        <= AIRBORNE;
                    charging_r     <= 1'b0;
                    charge_level_r <= LVL_ZERO;
                    frame_cnt_r    <= CNT_ZERO;
                end
            endcase
        end
    end

    assign jump_req     = jump_req_r;
    assign jump_vel     = jump_vel_r;
    assign jump_dir     = jump_dir_r;
    assign charging     = charging_r;
    assign charge_level = charge_level_r;

endmodule
